// File: rtl/bit_serial_scheduler.sv
// rtl/bit_serial_scheduler.sv - emits one indexed beat per set bit of a 16-bit word, MSB first

// decoder_4to16: index 0 selects bit 15, index 15 selects bit 0
module decoder_4to16 (
    input  logic [3:0]  sel_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);
    // pure decode, gated by enable
    always_comb begin
        onehot_o = 16'h0000;
        if (en_i) begin
            onehot_o = 16'h8000 >> sel_i;
        end
    end
endmodule

module bit_serial_scheduler #(
    parameter int EMIT_EMPTY = 1,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      in_word,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [3:0]       out_idx,
    output logic [15:0]      out_onehot,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_last,
    output logic             out_empty,
    output logic [CNT_W-1:0] out_seq
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [15:0]      res_q, res_d;
    logic [CNT_W-1:0] seq_q, seq_d;

    logic [3:0]  hi_idx;
    logic        res_le1;
    logic        res_zero;
    logic        busy_out;
    logic        in_xfer;
    logic        beat_xfer;
    logic        drop_word;

    // locate the highest set residue bit (index 0 = bit 15) and classify residue
    always_comb begin
        hi_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (res_q[i]) begin
                hi_idx = 4'(15 - i);
            end
        end
        res_le1  = ((res_q & (res_q - 16'd1)) == 16'd0);
        res_zero = (res_q == 16'd0);
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: a new word wins over returning to IDLE after the last beat
    always_comb begin
        state_d = state_q;
        if (in_xfer) begin
            state_d = drop_word ? IDLE : BUSY;
        end else if (beat_xfer && out_last) begin
            state_d = IDLE;
        end
    end

    // outputs: Moore on state/residue, held quiet while reset is asserted
    always_comb begin
        busy_out  = (state_q == BUSY) && !reset;
        out_val   = busy_out;
        out_idx   = busy_out ? hi_idx : 4'd0;
        out_last  = busy_out && res_le1;
        out_empty = busy_out && res_zero;
        out_seq   = seq_q;
        in_rdy    = !reset && ((state_q == IDLE) || ((state_q == BUSY) && res_le1 && out_rdy));
        in_xfer   = in_val && in_rdy;
        beat_xfer = out_val && out_rdy;
        drop_word = (in_word == 16'd0) && (EMIT_EMPTY == 0);
    end

    // residue and beat counter next values
    always_comb begin
        res_d = res_q;
        seq_d = seq_q;
        if (in_xfer) begin
            res_d = in_word;
            seq_d = '0;
        end else if (beat_xfer) begin
            res_d = res_q & ~(16'h8000 >> hi_idx);
            seq_d = seq_q + CNT_W'(1);
        end
    end

    // residue and beat counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= 16'd0;
            seq_q <= '0;
        end else begin
            res_q <= res_d;
            seq_q <= seq_d;
        end
    end

    decoder_4to16 u_dec (
        .sel_i    (out_idx),
        .en_i     (out_val && !out_empty),
        .onehot_o (out_onehot)
    );
endmodule

// File: tb/tb_bit_serial_scheduler.sv
// tb/tb_bit_serial_scheduler.sv - randomized and directed bench against a beat-queue model
`timescale 1ns/1ps
module tb_bit_serial_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_word = 16'd0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [3:0]  out_idx;
    logic [15:0] out_onehot;
    logic        out_val;
    logic        out_rdy = 1'b0;
    logic        out_last;
    logic        out_empty;
    logic [4:0]  out_seq;

    logic [15:0] in_word0 = 16'd0;
    logic        in_val0 = 1'b0;
    logic        in_rdy0;
    logic [3:0]  out_idx0;
    logic [15:0] out_onehot0;
    logic        out_val0;
    logic        out_last0;
    logic        out_empty0;
    logic [4:0]  out_seq0;

    always #5 clk = ~clk;

    bit_serial_scheduler #(.EMIT_EMPTY(1), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .in_word(in_word), .in_val(in_val), .in_rdy(in_rdy),
        .out_idx(out_idx), .out_onehot(out_onehot), .out_val(out_val), .out_rdy(out_rdy),
        .out_last(out_last), .out_empty(out_empty), .out_seq(out_seq)
    );

    bit_serial_scheduler #(.EMIT_EMPTY(0), .CNT_W(5)) dut0 (
        .clk(clk), .reset(reset), .in_word(in_word0), .in_val(in_val0), .in_rdy(in_rdy0),
        .out_idx(out_idx0), .out_onehot(out_onehot0), .out_val(out_val0), .out_rdy(1'b1),
        .out_last(out_last0), .out_empty(out_empty0), .out_seq(out_seq0)
    );

    typedef struct {
        int idx;
        bit last;
        bit empty;
        int seq;
    } beat_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // expand a word into its expected beats from the set bits, MSB first
    task automatic push_word(input logic [15:0] w);
        int pc = 0;
        int k = 0;
        beat_t b;
        for (int i = 0; i < 16; i++) pc += w[i];
        if (w == 16'd0) begin
            b.idx = 0; b.last = 1; b.empty = 1; b.seq = 0;
            q.push_back(b);
        end else begin
            for (int bit_pos = 15; bit_pos >= 0; bit_pos--) begin
                if (w[bit_pos]) begin
                    b.idx = 15 - bit_pos; b.last = (k == pc - 1); b.empty = 0; b.seq = k;
                    q.push_back(b);
                    k++;
                end
            end
        end
    endtask

    // one cycle: drive after negedge, check against model, update model
    task automatic step(input bit rst, input bit v, input logic [15:0] w, input bit r);
        bit exp_val;
        bit exp_rdy;
        logic [15:0] exp_oh;
        @(negedge clk);
        reset = rst; in_val = v; in_word = w; out_rdy = r;
        #1;
        exp_val = !rst && (q.size() > 0);
        exp_rdy = !rst && ((q.size() == 0) || (q.size() == 1 && r));
        check_val("out_val", out_val, exp_val);
        check_val("in_rdy", in_rdy, exp_rdy);
        if (exp_val) begin
            exp_oh = q[0].empty ? 16'h0000 : (16'h0001 << (15 - q[0].idx));
            check_val("out_idx", out_idx, q[0].idx);
            check_val("out_onehot", out_onehot, exp_oh);
            check_val("out_last", out_last, q[0].last);
            check_val("out_empty", out_empty, q[0].empty);
            check_val("out_seq", out_seq, q[0].seq);
        end else begin
            check_val("idle_idx", out_idx, 0);
            check_val("idle_onehot", out_onehot, 0);
            check_val("idle_last", out_last, 0);
            check_val("idle_empty", out_empty, 0);
        end
        if (rst) begin
            q.delete();
            acc = 0;
        end else begin
            if (exp_val && r) void'(q.pop_front());
            acc = v && exp_rdy;
            if (acc) push_word(w);
        end
    endtask

    initial begin
        logic [15:0] rw;
        int guard;

        step(1, 0, 16'd0, 0);
        step(1, 0, 16'd0, 0);
        step(0, 0, 16'd0, 1);
        check_val("reset_seq", out_seq, 0);
        check_val("reset_in_rdy", in_rdy, 1);

        // 1: sparse word, first beat right after accept
        step(0, 1, 16'hA001, 1);
        check_val("t1_accept", acc, 1);
        step(0, 0, 16'd0, 1);
        check_val("t1_b0_idx", out_idx, 0);
        check_val("t1_b0_oh", out_onehot, 16'h8000);
        check_val("t1_b0_last", out_last, 0);
        step(0, 0, 16'd0, 1);
        check_val("t1_b1_oh", out_onehot, 16'h2000);
        check_val("t1_b1_seq", out_seq, 1);
        step(0, 0, 16'd0, 1);
        check_val("t1_b2_oh", out_onehot, 16'h0001);
        check_val("t1_b2_last", out_last, 1);
        check_val("t1_b2_seq", out_seq, 2);

        // 2: full word then back-to-back single-bit words
        step(0, 1, 16'hFFFF, 1);
        repeat (15) step(0, 0, 16'd0, 1);
        step(0, 1, 16'h0100, 1);
        check_val("t2_b15_idx", out_idx, 15);
        check_val("t2_b15_seq", out_seq, 15);
        check_val("t2_b15_last", out_last, 1);
        check_val("t2_accept1", acc, 1);
        step(0, 1, 16'h0002, 1);
        check_val("t2_w1_idx", out_idx, 7);
        check_val("t2_accept2", acc, 1);
        step(0, 0, 16'd0, 1);
        check_val("t2_w2_val", out_val, 1);
        check_val("t2_w2_idx", out_idx, 14);
        step(0, 0, 16'd0, 1);

        // 3: zero word, both EMIT_EMPTY settings
        step(0, 1, 16'h0000, 1);
        step(0, 0, 16'd0, 1);
        check_val("t3_empty", out_empty, 1);
        check_val("t3_last", out_last, 1);
        check_val("t3_oh", out_onehot, 0);
        @(negedge clk);
        in_val0 = 1; in_word0 = 16'h0000;
        #1 check_val("t3_e0_rdy_a", in_rdy0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_val0 = 0;
            #1;
            check_val("t3_e0_val", out_val0, 0);
            check_val("t3_e0_rdy", in_rdy0, 1);
        end
        step(0, 0, 16'd0, 1);

        // 4: stall on the first beat
        step(0, 1, 16'h0C00, 1);
        repeat (3) begin
            step(0, 0, 16'd0, 0);
            check_val("t4_hold_idx", out_idx, 4);
            check_val("t4_hold_oh", out_onehot, 16'h0800);
            check_val("t4_hold_seq", out_seq, 0);
            check_val("t4_hold_rdy", in_rdy, 0);
        end
        step(0, 0, 16'd0, 1);
        step(0, 0, 16'd0, 1);
        check_val("t4_b1_idx", out_idx, 5);
        check_val("t4_b1_last", out_last, 1);

        // 5: reset in mid-word
        step(0, 1, 16'hFFFF, 1);
        repeat (5) step(0, 0, 16'd0, 1);
        step(1, 0, 16'd0, 1);
        step(0, 0, 16'd0, 1);
        check_val("t5_val_after", out_val, 0);
        check_val("t5_rdy_after", in_rdy, 1);
        step(0, 1, 16'h8000, 1);
        step(0, 0, 16'd0, 1);
        check_val("t5_idx", out_idx, 0);
        check_val("t5_seq", out_seq, 0);
        check_val("t5_last", out_last, 1);
        step(0, 0, 16'd0, 1);

        // 6: random words and back-pressure against the model
        for (int n = 0; n < 600; n++) begin
            case ($urandom % 4)
                0: rw = 16'd0;
                1: rw = 16'h0001 << ($urandom % 16);
                default: rw = 16'($urandom);
            endcase
            step(($urandom % 150) == 0, ($urandom % 3) != 0, rw, ($urandom % 4) != 0);
        end
        guard = 0;
        while (q.size() > 0 && guard < 40) begin
            step(0, 0, 16'd0, 1);
            guard++;
        end
        check_val("drain_done", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
